router_pkt_src: RTL

Packet source for the 1x3 router input port: the transmit side of the router's `pkt_vld`/`busy` byte protocol. It buffers payload bytes from a local client in a 64-byte FIFO. On command it emits header, payload and parity byte to the router, stalling while the router asserts `busy`. It sits between a test or host client and the router top-level `data_in`/`pkt_vld`/`busy`/`err` pins.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_src_fifo.sv | 79 +++++++
 rtl/router_pkt_src.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: byte width, length limit,
// invalid destination code, FSM state encoding and the header byte helper.
// No logic of its own; imported by the packet source and its FIFO.
package router_pkg;

  localparam int ROUTER_DW      = 8;
  localparam int ROUTER_MAX_LEN = 63;

  // Destination code 3 does not exist on the 1x3 router.
  localparam logic [1:0] ROUTER_INVALID_ADDR = 2'b11;

  // Packet source FSM encoding.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_PLD  = 3'd2;
  localparam logic [2:0] ST_PAR  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Header byte: payload length in the upper six bits, destination in the lower two.
  function automatic logic [ROUTER_DW-1:0] router_hdr(input logic [5:0] len,
                                                      input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_src_fifo.sv
// Payload FIFO: DEPTH x DW storage with show-ahead read data and occupancy count.
// Latency: a write is visible on rdata/count the cycle after its strobe.
// Backpressure: writes while full and reads while empty are ignored; write+read both happen.
module router_src_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths stay correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  // Next pointers and occupancy; a flush empties the FIFO regardless of strobes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/router_pkt_src.sv
// Router packet source: buffers payload, then sends header, payload and parity to the router.
// Latency: header on data_out the cycle after an accepted start; one byte per unstalled cycle.
// Backpressure: router busy holds the current byte; FIFO drops writes while full.
// Optional build macro ROUTER_PKT_SRC_PARINJ_EN adds par_inj to corrupt parity bit 0.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int DW    = ROUTER_DW,
  parameter int DEPTH = 64            // must hold a maximum-length packet (>= 63)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pld_wr,
  input  logic [DW-1:0] pld_data,
  output logic          pld_full,
  input  logic          start,
  input  logic [1:0]    cmd_addr,
  input  logic [5:0]    cmd_len,
  output logic          cmd_rdy,
  output logic          cmd_err,
  output logic          done,
  output logic [DW-1:0] data_out,
  output logic          pkt_vld,
  input  logic          busy,
  input  logic          err,
`ifdef ROUTER_PKT_SRC_PARINJ_EN
  input  logic          par_inj,
`endif
  output logic          pkt_err
);

  localparam int LW = $clog2(ROUTER_MAX_LEN + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] par_q, par_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          vld_q, vld_d;
  logic          cmd_err_q, cmd_err_d;
  logic          done_q, done_d;
  logic          pkt_err_q, pkt_err_d;

  logic [DW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          pop;
  logic          cmd_ok, accept;
  logic          inj_bit;
  logic [DW-1:0] hdr;

  router_src_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (1'b0),
    .wr    (pld_wr),
    .wdata (pld_data),
    .rd    (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hdr    = router_hdr(cmd_len, cmd_addr);
  // Whole payload must already be buffered so the packet never starves mid-flight.
  assign cmd_ok = (cmd_addr != ROUTER_INVALID_ADDR) && (cmd_len != '0) &&
                  !fifo_empty && (fifo_count >= CW'(cmd_len));
  assign accept = (state_q == ST_IDLE) && start && cmd_ok;

`ifdef ROUTER_PKT_SRC_PARINJ_EN
  logic inj_q;

  // Parity corruption request is captured with the command and held for the packet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       inj_q <= 1'b0;
    else if (accept) inj_q <= par_inj;
  end
  assign inj_bit = inj_q;
`else
  assign inj_bit = 1'b0;
`endif

  // Packet sequencing: each byte advances only on a cycle where busy is low.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    vld_d     = vld_q;
    rem_d     = rem_q;
    par_d     = par_q;
    cmd_err_d = 1'b0;
    done_d    = 1'b0;
    pop       = 1'b0;
    pkt_err_d = pkt_err_q | err;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cmd_ok) begin
            state_d   = ST_HDR;
            data_d    = hdr;
            vld_d     = 1'b1;
            par_d     = hdr;
            // Counts bytes still to load after the first payload byte.
            rem_d     = cmd_len - LW'(1);
            pkt_err_d = err;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (!busy) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          par_d   = par_q ^ fifo_rdata;
          state_d = ST_PLD;
        end
      end
      ST_PLD: begin
        if (!busy) begin
          if (rem_q == '0) begin
            state_d = ST_PAR;
            vld_d   = 1'b0;
            data_d  = par_q ^ {{(DW-1){1'b0}}, inj_bit};
          end else begin
            pop    = 1'b1;
            data_d = fifo_rdata;
            par_d  = par_q ^ fifo_rdata;
            rem_d  = rem_q - LW'(1);
          end
        end
      end
      ST_PAR: begin
        if (!busy) begin
          state_d = ST_DONE;
          data_d  = '0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        data_d  = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      vld_q     <= 1'b0;
      rem_q     <= '0;
      par_q     <= '0;
      cmd_err_q <= 1'b0;
      done_q    <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      rem_q     <= rem_d;
      par_q     <= par_d;
      cmd_err_q <= cmd_err_d;
      done_q    <= done_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  assign data_out = data_q;
  assign pkt_vld  = vld_q;
  assign cmd_err  = cmd_err_q;
  assign done     = done_q;
  assign pkt_err  = pkt_err_q;
  assign cmd_rdy  = (state_q == ST_IDLE);
  assign pld_full = fifo_full;

endmodule
